// File: rtl/snoop_receptor_if.sv
`default_nettype none
// ============================================================================
// Module   : snoop_receptor_if
// Purpose  : Groups the coherence-bus snoop channel and the memory write-back
//            channel of the snoop receptor.
// Ports    : snoop_valid/snoop_ready/snoop_op/snoop_addr - incoming bus message
//            wb_valid/wb_ready/wb_addr/wb_data           - write-back request
// Modports : slave  - the receptor (consumes snoops, produces write-backs)
//            master - the bus/memory side
// Revision : 1.0 - initial release
// ============================================================================
interface snoop_receptor_if #(
    parameter int IDX_W  = 2,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
);
    logic                     snoop_valid;
    logic                     snoop_ready;
    logic [1:0]               snoop_op;
    logic [IDX_W+TAG_W-1:0]   snoop_addr;

    logic                     wb_valid;
    logic                     wb_ready;
    logic [IDX_W+TAG_W-1:0]   wb_addr;
    logic [DATA_W-1:0]        wb_data;

    modport slave (
        input  snoop_valid, snoop_op, snoop_addr, wb_ready,
        output snoop_ready, wb_valid, wb_addr, wb_data
    );

    modport master (
        output snoop_valid, snoop_op, snoop_addr, wb_ready,
        input  snoop_ready, wb_valid, wb_addr, wb_data
    );
endinterface
`default_nettype wire

// File: rtl/snoop_receptor.sv
`default_nettype none
// ============================================================================
// Module   : snoop_receptor
// Purpose  : Bus side of a snooping coherence protocol. Owns the state, tag
//            and data of a small direct-mapped cache, applies transitions
//            caused by remote bus messages and issues a write-back when a
//            remote miss hits a locally exclusive (dirty) line.
// Ports    : clock, reset   - rising-edge clock, asynchronous active-high reset
//            bus            - snoop channel + write-back channel (interface)
//            local_*        - local processor line write
//            probe_*        - combinational read of one line's state and tag
//            hit_count      - saturating count of snoop hits
//            protocol_err   - sticky: invalidate seen on an exclusive line
// Revision : 1.0 - initial release
// ============================================================================
module snoop_receptor #(
    parameter int IDX_W  = 2,
    parameter int TAG_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    snoop_receptor_if.slave   bus,
    input  logic              local_we,
    input  logic [IDX_W-1:0]  local_index,
    input  logic [TAG_W-1:0]  local_tag,
    input  logic [1:0]        local_state,
    input  logic [DATA_W-1:0] local_data,
    input  logic [IDX_W-1:0]  probe_index,
    output logic [1:0]        probe_state,
    output logic [TAG_W-1:0]  probe_tag,
    output logic [7:0]        hit_count,
    output logic              protocol_err
);
    localparam int LINES  = 2**IDX_W;
    localparam int ADDR_W = IDX_W + TAG_W;

    localparam logic [1:0] OP_READ_MISS  = 2'b00;
    localparam logic [1:0] OP_WRITE_MISS = 2'b01;
    localparam logic [1:0] OP_INVALIDATE = 2'b10;

    localparam logic [1:0] ST_INVALID    = 2'b00;
    localparam logic [1:0] ST_EXCLUSIVE  = 2'b01;
    localparam logic [1:0] ST_SHARED     = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WRITEBACK = 2'd2
    } fsm_t;

    fsm_t state;
    fsm_t state_next;

    logic [1:0]        line_state [LINES];
    logic [TAG_W-1:0]  line_tag   [LINES];
    logic [DATA_W-1:0] line_data  [LINES];

    logic [1:0]        lat_op;
    logic [ADDR_W-1:0] lat_addr;
    logic [IDX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]  lat_tag;
    logic              hit;

    // Control decoded by the FSM and applied by the datapath register block
    logic       accept;
    logic       local_apply;
    logic       upd_en;
    logic [1:0] upd_val;
    logic       load_wb;
    logic       hit_inc;
    logic       err_set;

    assign lat_idx = lat_addr[IDX_W-1:0];
    assign lat_tag = lat_addr[ADDR_W-1:IDX_W];
    assign hit     = (line_tag[lat_idx] == lat_tag) && (line_state[lat_idx] != ST_INVALID);

    assign probe_state = line_state[probe_index];
    assign probe_tag   = line_tag[probe_index];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state;
        bus.snoop_ready = 1'b0;
        bus.wb_valid    = 1'b0;
        accept          = 1'b0;
        local_apply     = 1'b0;
        upd_en          = 1'b0;
        upd_val         = ST_INVALID;
        load_wb         = 1'b0;
        hit_inc         = 1'b0;
        err_set         = 1'b0;

        case (state)
            IDLE: begin
                // A local write owns the array this cycle; the snoop waits.
                bus.snoop_ready = !local_we;
                local_apply     = local_we;
                if (bus.snoop_valid && !local_we) begin
                    accept     = 1'b1;
                    state_next = LOOKUP;
                end
            end

            LOOKUP: begin
                state_next = IDLE;
                if (hit) begin
                    hit_inc = 1'b1;
                    case (lat_op)
                        OP_READ_MISS: begin
                            if (line_state[lat_idx] == ST_EXCLUSIVE) begin
                                load_wb    = 1'b1;
                                state_next = WRITEBACK;
                            end
                        end
                        OP_WRITE_MISS: begin
                            if (line_state[lat_idx] == ST_EXCLUSIVE) begin
                                load_wb    = 1'b1;
                                state_next = WRITEBACK;
                            end else begin
                                upd_en  = 1'b1;
                                upd_val = ST_INVALID;
                            end
                        end
                        OP_INVALIDATE: begin
                            // Nobody else may hold a copy of an exclusive line,
                            // so a remote invalidate of one is a protocol error.
                            upd_en  = 1'b1;
                            upd_val = ST_INVALID;
                            err_set = (line_state[lat_idx] == ST_EXCLUSIVE);
                        end
                        default: ;
                    endcase
                end
            end

            WRITEBACK: begin
                bus.wb_valid = 1'b1;
                if (bus.wb_ready) begin
                    upd_en     = 1'b1;
                    upd_val    = (lat_op == OP_READ_MISS) ? ST_SHARED : ST_INVALID;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Line array, latched snoop, write-back registers and status
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                line_state[i[IDX_W-1:0]] <= ST_INVALID;
                line_tag[i[IDX_W-1:0]]   <= '0;
                line_data[i[IDX_W-1:0]]  <= '0;
            end
            lat_op       <= '0;
            lat_addr     <= '0;
            bus.wb_addr  <= '0;
            bus.wb_data  <= '0;
            hit_count    <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (local_apply) begin
                // The reserved encoding is stored as invalid.
                line_state[local_index] <= (local_state == 2'b11) ? ST_INVALID : local_state;
                line_tag[local_index]   <= local_tag;
                line_data[local_index]  <= local_data;
            end
            if (upd_en) begin
                line_state[lat_idx] <= upd_val;
            end
            if (accept) begin
                lat_op   <= bus.snoop_op;
                lat_addr <= bus.snoop_addr;
            end
            if (load_wb) begin
                bus.wb_addr <= {line_tag[lat_idx], lat_idx};
                bus.wb_data <= line_data[lat_idx];
            end
            if (hit_inc && (hit_count != 8'hFF)) begin
                hit_count <= hit_count + 8'd1;
            end
            if (err_set) begin
                protocol_err <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_snoop_receptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_snoop_receptor
// Purpose  : Directed self-checking bench for snoop_receptor. Expected
//            write-backs are queued when the snoop is driven and popped when
//            the handshake happens; hit counts come from a bench-side model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snoop_receptor;
    localparam int IDX_W  = 2;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = IDX_W + TAG_W;

    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] WR = 2'b01;
    localparam logic [1:0] INV = 2'b10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    snoop_receptor_if #(.IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) bus_if ();

    logic              local_we    = 1'b0;
    logic [IDX_W-1:0]  local_index = '0;
    logic [TAG_W-1:0]  local_tag   = '0;
    logic [1:0]        local_state = '0;
    logic [DATA_W-1:0] local_data  = '0;
    logic [IDX_W-1:0]  probe_index = '0;
    logic [1:0]        probe_state;
    logic [TAG_W-1:0]  probe_tag;
    logic [7:0]        hit_count;
    logic              protocol_err;

    snoop_receptor #(.IDX_W(IDX_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus_if),
        .local_we     (local_we),
        .local_index  (local_index),
        .local_tag    (local_tag),
        .local_state  (local_state),
        .local_data   (local_data),
        .probe_index  (probe_index),
        .probe_state  (probe_state),
        .probe_tag    (probe_tag),
        .hit_count    (hit_count),
        .protocol_err (protocol_err)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    wb_t wb_q[$];
    wb_t wb_exp;

    int checks    = 0;
    int passes    = 0;
    int fails     = 0;
    int exp_hits  = 0;
    int wb_cycles = 0;
    int wb_snap   = 0;

    always @(posedge clock) begin
        if (bus_if.wb_valid === 1'b1) wb_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic probe(input logic [IDX_W-1:0] idx, input logic [1:0] st,
                         input logic [TAG_W-1:0] tg, input string tag);
        probe_index = idx;
        #1;
        check({tag, "_state"}, 32'(probe_state), 32'(st));
        check({tag, "_tag"},   32'(probe_tag),   32'(tg));
    endtask

    task automatic local_write(input logic [IDX_W-1:0] idx, input logic [TAG_W-1:0] tg,
                               input logic [1:0] st, input logic [DATA_W-1:0] d);
        local_we    = 1'b1;
        local_index = idx;
        local_tag   = tg;
        local_state = st;
        local_data  = d;
        tick();
        local_we    = 1'b0;
    endtask

    // Presents one snoop for a single accept edge; returns in the lookup cycle.
    task automatic snoop(input logic [1:0] op, input logic [ADDR_W-1:0] addr, input string tag);
        bus_if.snoop_op    = op;
        bus_if.snoop_addr  = addr;
        bus_if.snoop_valid = 1'b1;
        #1;
        check({tag, "_ready"}, 32'(bus_if.snoop_ready), 32'd1);
        tick();
        bus_if.snoop_valid = 1'b0;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    initial begin
        bus_if.snoop_valid = 1'b0;
        bus_if.snoop_op    = 2'b11;
        bus_if.snoop_addr  = '0;
        bus_if.wb_ready    = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) probe(IDX_W'(i), 2'b00, 4'd0, "rst_probe");
        check("rst_wb_valid",  32'(bus_if.wb_valid),    32'd0);
        check("rst_hit_count", 32'(hit_count),          32'd0);
        check("rst_ready",     32'(bus_if.snoop_ready), 32'd1);
        check("rst_err",       32'(protocol_err),       32'd0);

        // ---------------- shared line, remote write_miss ----------------
        wb_snap = wb_cycles;
        local_write(2'd1, 4'd5, 2'b10, 8'h11);
        probe(2'd1, 2'b10, 4'd5, "shr_written");
        snoop(WR, {4'd5, 2'd1}, "shr_wm");
        exp_hits = sat_inc(exp_hits);
        tick();
        probe(2'd1, 2'b00, 4'd5, "shr_wm_inval");
        check("shr_wm_hits", 32'(hit_count), 32'(exp_hits));
        tick();
        check("shr_wm_no_wb", 32'(wb_cycles - wb_snap), 32'd0);

        // ---------------- exclusive line, read_miss, stalled write-back ----------------
        local_write(2'd2, 4'd3, 2'b01, 8'hA5);
        wb_q.push_back('{addr: {4'd3, 2'd2}, data: 8'hA5});
        snoop(RD, {4'd3, 2'd2}, "exc_rm");
        exp_hits = sat_inc(exp_hits);
        check("exc_rm_wb_early", 32'(bus_if.wb_valid), 32'd0);
        tick();
        wb_exp = wb_q[0];
        for (int c = 0; c < 4; c++) begin
            check("exc_rm_wb_valid", 32'(bus_if.wb_valid), 32'd1);
            check("exc_rm_wb_addr",  32'(bus_if.wb_addr),  32'(wb_exp.addr));
            check("exc_rm_wb_data",  32'(bus_if.wb_data),  32'(wb_exp.data));
            check("exc_rm_ready",    32'(bus_if.snoop_ready), 32'd0);
            probe(2'd2, 2'b01, 4'd3, "exc_rm_hold");
            if (c < 3) tick();
        end
        bus_if.wb_ready = 1'b1;
        wb_exp = wb_q.pop_front();
        #1;
        check("exc_rm_hs_addr", 32'(bus_if.wb_addr), 32'(wb_exp.addr));
        check("exc_rm_hs_data", 32'(bus_if.wb_data), 32'(wb_exp.data));
        tick();
        bus_if.wb_ready = 1'b0;
        check("exc_rm_wb_drop", 32'(bus_if.wb_valid), 32'd0);
        probe(2'd2, 2'b10, 4'd3, "exc_rm_shared");
        check("exc_rm_hits", 32'(hit_count), 32'(exp_hits));

        // ---------------- exclusive line, invalidate -> protocol error ----------------
        local_write(2'd0, 4'd7, 2'b01, 8'h5A);
        snoop(INV, {4'd7, 2'd0}, "exc_inv");
        exp_hits = sat_inc(exp_hits);
        tick();
        probe(2'd0, 2'b00, 4'd7, "exc_inv_line");
        check("exc_inv_err",  32'(protocol_err), 32'd1);
        check("exc_inv_hits", 32'(hit_count),    32'(exp_hits));
        snoop(RD, {4'd3, 2'd2}, "shr_rm");
        exp_hits = sat_inc(exp_hits);
        tick();
        probe(2'd2, 2'b10, 4'd3, "shr_rm_stays");
        check("err_sticky", 32'(protocol_err), 32'd1);
        // same index, different tag: miss
        snoop(RD, {4'd9, 2'd2}, "tag_miss");
        tick();
        probe(2'd2, 2'b10, 4'd3, "tag_miss_line");
        check("tag_miss_hits", 32'(hit_count), 32'(exp_hits));

        // ---------------- local write and snoop in the same cycle ----------------
        local_we           = 1'b1;
        local_index        = 2'd3;
        local_tag          = 4'd6;
        local_state        = 2'b10;
        local_data         = 8'h77;
        bus_if.snoop_op    = RD;
        bus_if.snoop_addr  = {4'd6, 2'd3};
        bus_if.snoop_valid = 1'b1;
        #1;
        check("coll_ready_low", 32'(bus_if.snoop_ready), 32'd0);
        tick();
        local_we = 1'b0;
        #1;
        check("coll_ready_next", 32'(bus_if.snoop_ready), 32'd1);
        probe(2'd3, 2'b10, 4'd6, "coll_local");
        tick();
        bus_if.snoop_valid = 1'b0;
        exp_hits = sat_inc(exp_hits);
        tick();
        check("coll_hits", 32'(hit_count), 32'(exp_hits));

        // ---------------- reset during write-back ----------------
        local_write(2'd1, 4'd2, 2'b01, 8'h3C);
        snoop(RD, {4'd2, 2'd1}, "rst_wb");
        tick();
        check("rst_wb_valid_pre", 32'(bus_if.wb_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_wb_async",  32'(bus_if.wb_valid), 32'd0);
        check("rst_wb_addr",   32'(bus_if.wb_addr),  32'd0);
        check("rst_wb_hits",   32'(hit_count),       32'd0);
        check("rst_wb_err",    32'(protocol_err),    32'd0);
        tick();
        reset = 1'b0;
        exp_hits = 0;
        for (int i = 0; i < 4; i++) probe(IDX_W'(i), 2'b00, 4'd0, "rst_wb_probe");
        tick();
        check("rst_wb_no_retry", 32'(bus_if.wb_valid), 32'd0);

        // ---------------- hit counter saturation ----------------
        local_write(2'd0, 4'd1, 2'b10, 8'h01);
        for (int k = 1; k <= 256; k++) begin
            snoop(RD, {4'd1, 2'd0}, "sat");
            exp_hits = sat_inc(exp_hits);
            tick();
            if (k >= 254) check("sat_hits", 32'(hit_count), 32'(exp_hits));
        end
        probe(2'd0, 2'b10, 4'd1, "sat_line");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/snoop_receptor.md
Name: snoop_receptor

Overview:
- Bus-side end of the snooping coherence protocol: receives coherence messages other processors put on the shared bus and applies the resulting transitions to the local cache-line state array.
- Owns the per-line state, tag and data of a small direct-mapped cache.
- Issues a write-back handshake when a remote miss hits a locally exclusive (dirty) line.
- The local processor side writes lines through a local update port.

Parameters:
- IDX_W, 2, line index width (LINES = 2**IDX_W)
- TAG_W, 4, tag width
- DATA_W, 8, line data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- snoop_valid  in  1  bus message present
- snoop_ready  out  1  receptor can accept a message this cycle
- snoop_op  in  2  00 read_miss, 01 write_miss, 10 invalidate, 11 empty
- snoop_addr  in  IDX_W+TAG_W  index = low IDX_W bits, tag = high TAG_W bits
- local_we  in  1  local processor writes one line
- local_index  in  IDX_W  line written
- local_tag  in  TAG_W  tag written
- local_state  in  2  00 invalid, 01 exclusive, 10 shared (11 reserved, stored as invalid)
- local_data  in  DATA_W  data written
- wb_valid  out  1  write-back request
- wb_ready  in  1  memory accepts write-back
- wb_addr  out  IDX_W+TAG_W  {tag, index} of written-back line
- wb_data  out  DATA_W  line data
- probe_index  in  IDX_W  combinational read index
- probe_state  out  2  state of probed line
- probe_tag  out  TAG_W  tag of probed line
- hit_count  out  8  snoop hits, saturating at 255
- protocol_err  out  1  sticky error flag

Behaviour:
- Reset (asynchronous):
  - All lines invalid; tags and data cleared.
  - FSM set to IDLE.
  - wb_valid=0, wb_addr=0, wb_data=0, hit_count=0, protocol_err=0.
  - A write-back in progress is dropped; there is no retry after reset.
- FSM states: IDLE, LOOKUP, WRITEBACK.
- IDLE:
  - snoop_ready = !local_we.
  - local_we has priority: the line write takes effect at the clock edge and no snoop is accepted that cycle.
  - snoop_valid && snoop_ready at edge T: op and addr are latched and the FSM moves to LOOKUP.
- LOOKUP (cycle T+1, snoop_ready=0, local_we ignored and not applied):
  - hit = (stored tag == latched tag) && state != invalid.
  - A hit increments hit_count, saturating at 255.
  - Miss, or op=empty -> IDLE, no state change.
  - shared + read_miss -> stays shared -> IDLE.
  - shared + write_miss or invalidate -> invalid at end of T+1 -> IDLE.
  - exclusive + invalidate -> invalid, protocol_err set (sticky) -> IDLE.
  - exclusive + read_miss or write_miss -> WRITEBACK; wb_addr and wb_data loaded from the line.
- WRITEBACK (from T+2):
  - wb_valid=1; wb_addr and wb_data are held stable until wb_valid && wb_ready.
  - On the handshake edge the line becomes shared (read_miss) or invalid (write_miss), wb_valid drops, and the FSM returns to IDLE.
  - snoop_ready=0 throughout; local_we ignored.
- Latency:
  - No write-back: new state visible on probe_* at T+2; next accept possible at edge T+2.
  - With write-back: wb_valid is first high in cycle T+2; the minimum round trip is 3 cycles when wb_ready is already high.
- probe_state and probe_tag are purely combinational from the array and reflect updates the cycle after the update edge.
- A snoop to a line with the same index but a different tag is a miss: no write-back, no change.

Test Plan:
- Reset, then probe every index -> state 00, tag 0; wb_valid=0, hit_count=0, snoop_ready=1.
- local_we idx1, tag 5, shared; snoop write_miss addr {5,1} -> probe idx1 = invalid at T+2; hit_count=1; wb_valid never asserted.
- local_we idx2, tag 3, exclusive, data 0xA5; snoop read_miss {3,2}; wb_ready held 0 for 4 cycles, then 1 -> wb_valid high from T+2 with wb_addr={3,2} and wb_data=0xA5 stable; idx2 becomes shared on the handshake edge.
- Exclusive line, snoop invalidate -> line invalid, protocol_err=1 and still 1 after later valid snoops.
- local_we and snoop_valid in the same IDLE cycle -> snoop_ready=0, local write applied, snoop accepted the next cycle.
- Assert reset during WRITEBACK -> wb_valid=0 immediately (asynchronous); all lines invalid; 256 hits on shared-line read_misses -> hit_count holds 255.
